// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: ROM port, redirect request and the decode-side handshake.
// master = fetch stage, slave = ROM/decode/branch-unit side.
interface fetch_queue_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]        rom_addr;
    logic [31:0]                  rom_data;
    logic                         PCSrc;
    logic [ADDR_WIDTH-1:0]        branch_target;
    logic [31:0]                  instr;
    logic [ADDR_WIDTH-1:0]        pc;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         misaligned;

    modport master (
        output rom_addr, instr, pc, instr_valid, count, misaligned,
        input  rom_data, PCSrc, branch_target, instr_ready
    );

    modport slave (
        input  rom_addr, instr, pc, instr_valid, count, misaligned,
        output rom_data, PCSrc, branch_target, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a prefetch FIFO of {pc, instr} pairs.
// Fetches one word per cycle while there is room; a redirect flushes the queue.
module fetch_queue #(
    parameter int unsigned          DEPTH      = 4,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]           instr_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  mis_q, mis_d;

    logic                  not_empty;
    logic                  pop;
    logic                  push;
    logic                  wr_en;

    // Handshake decode; a full queue can still accept a word when the head leaves.
    always_comb begin
        not_empty = (count_q != '0);
        pop       = not_empty & bus.instr_ready;
        push      = (count_q < CntW'(DEPTH)) | pop;
        wr_en     = push & ~bus.PCSrc & ~rst;
    end

    // Next-state: redirect wins over push/pop and empties the queue.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mis_d      = 1'b0;
        if (bus.PCSrc) begin
            fetch_pc_d = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            mis_d      = |bus.branch_target[1:0];
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mis_q      <= mis_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= bus.rom_data;
        end
    end

    // Outputs: head entry, zeroed when the queue is empty.
    always_comb begin
        bus.rom_addr    = fetch_pc_q;
        bus.count       = count_q;
        bus.misaligned  = mis_q;
        bus.instr_valid = not_empty;
        bus.instr       = not_empty ? instr_mem[rd_ptr_q] : 32'd0;
        bus.pc          = not_empty ? pc_mem[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

    fetch_queue #(
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Combinational ROM: word at byte address n is 0x1000_0000 + n.
    assign bus.rom_data = 32'h1000_0000 + bus.rom_addr;

    // Reference model state.
    logic [31:0] m_q[$];
    logic [31:0] m_fetch;
    logic        m_mis;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance the model by one clock edge given the inputs applied before it.
    task automatic model_edge(input bit r, input bit p, input logic [31:0] t, input bit rdy);
        bit do_pop;
        bit full;
        if (r) begin
            m_q.delete();
            m_fetch = 32'h0;
            m_mis   = 1'b0;
        end else if (p) begin
            m_q.delete();
            m_fetch = t & ~32'h3;
            m_mis   = (t[1:0] != 2'b00);
        end else begin
            m_mis  = 1'b0;
            do_pop = (m_q.size() > 0) && rdy;
            full   = (m_q.size() == DEPTH);
            if (do_pop) void'(m_q.pop_front());
            if (!full || do_pop) begin
                m_q.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PCSrc = 1'b1;
        bus.branch_target = 32'h47;
        bus.instr_ready = 1'b1;
        tick();
        tick();
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.rom_addr !== 32'h0) begin bad++; $display("FAIL reset_rom_addr got=%h want=0", bus.rom_addr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.instr_valid); end
        total++; if (bus.instr !== 32'h0 || bus.pc !== 32'h0) begin bad++; $display("FAIL reset_head got instr=%h pc=%h want 0/0", bus.instr, bus.pc); end
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b want=0", bus.misaligned); end
    endtask

    task automatic test_fill();
        rst = 1'b0;
        bus.PCSrc = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h0) begin bad++; $display("FAIL first_fetch got valid=%b pc=%h want 1/0", bus.instr_valid, bus.pc); end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count%0d got=%0d want=4", k, bus.count); end
            total++; if (bus.rom_addr !== 32'h10) begin bad++; $display("FAIL fill_rom_addr%0d got=%h want=10", k, bus.rom_addr); end
            total++; if (bus.pc !== 32'h0 || bus.instr !== 32'h1000_0000) begin bad++; $display("FAIL fill_head%0d got pc=%h instr=%h want 0/10000000", k, bus.pc, bus.instr); end
            tick();
        end
    endtask

    task automatic test_stream();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d got=%h want=%h", i, bus.pc, 32'(4 * i)); end
            total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL stream_count%0d got=%0d want=4", i, bus.count); end
            tick();
        end
    endtask

    task automatic test_redirect();
        bus.instr_ready = 1'b1;
        bus.PCSrc = 1'b1;
        bus.branch_target = 32'h80;
        tick();
        bus.PCSrc = 1'b0;
        total++; if (bus.instr_valid !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("FAIL redir_flush got valid=%b count=%0d want 0/0", bus.instr_valid, bus.count); end
        total++; if (bus.rom_addr !== 32'h80) begin bad++; $display("FAIL redir_rom_addr got=%h want=80", bus.rom_addr); end
        tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h80 || bus.instr !== 32'h1000_0080) begin
            bad++; $display("FAIL redir_head got valid=%b pc=%h instr=%h want 1/80/10000080", bus.instr_valid, bus.pc, bus.instr);
        end
    endtask

    task automatic test_misaligned();
        bus.instr_ready = 1'b0;
        bus.PCSrc = 1'b1;
        bus.branch_target = 32'h82;
        tick();
        bus.PCSrc = 1'b0;
        total++; if (bus.misaligned !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b want=1", bus.misaligned); end
        total++; if (bus.rom_addr !== 32'h80) begin bad++; $display("FAIL mis_rom_addr got=%h want=80", bus.rom_addr); end
        tick();
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", bus.misaligned); end
        total++; if (bus.pc !== 32'h80) begin bad++; $display("FAIL mis_head got=%h want=80", bus.pc); end
    endtask

    task automatic test_reset_mid();
        bus.instr_ready = 1'b0;
        bus.PCSrc = 1'b1;
        bus.branch_target = 32'h100;
        tick();
        bus.PCSrc = 1'b0;
        repeat (3) tick();
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL mid_fill got=%0d want=3", bus.count); end
        rst = 1'b1;
        bus.PCSrc = 1'b1;
        bus.branch_target = 32'h43;
        bus.instr_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.PCSrc = 1'b0;
        total++; if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_count got count=%0d valid=%b want 0/0", bus.count, bus.instr_valid); end
        total++; if (bus.rom_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_rom_addr got=%h want=0", bus.rom_addr); end
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL mid_rst_mis got=%b want=0", bus.misaligned); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        bit          exp_valid;
        int          bias;
        rst = 1'b1;
        bus.PCSrc = 1'b0;
        model_edge(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 500; c++) begin
            exp_valid = (m_q.size() > 0);
            exp_pc    = exp_valid ? m_q[0] : 32'h0;
            total++; if (bus.instr_valid !== exp_valid || bus.pc !== exp_pc) begin
                bad++; $display("FAIL rand_head c=%0d got valid=%b pc=%h want %b/%h", c, bus.instr_valid, bus.pc, exp_valid, exp_pc);
            end
            total++; if (bus.instr !== (exp_valid ? 32'h1000_0000 + exp_pc : 32'h0)) begin
                bad++; $display("FAIL rand_instr c=%0d got=%h", c, bus.instr);
            end
            total++; if (bus.count !== 3'(m_q.size()) || bus.count > 3'(DEPTH)) begin
                bad++; $display("FAIL rand_count c=%0d got=%0d want=%0d", c, bus.count, m_q.size());
            end
            total++; if (bus.rom_addr !== m_fetch || bus.misaligned !== m_mis) begin
                bad++; $display("FAIL rand_fetch c=%0d got addr=%h mis=%b want %h/%b", c, bus.rom_addr, bus.misaligned, m_fetch, m_mis);
            end
            bias = ((c / 100) % 2 == 1) ? 80 : 30;
            bus.instr_ready = ($urandom_range(0, 99) < bias);
            bus.PCSrc = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.branch_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else bus.branch_target = $urandom & 32'hFFF;
            model_edge(1'b0, bus.PCSrc, bus.branch_target, bus.instr_ready);
            tick();
        end
        bus.PCSrc = 1'b0;
    endtask

    initial begin
        bus.PCSrc = 1'b0;
        bus.branch_target = 32'h0;
        bus.instr_ready = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
